sdram_pro_init_monitor: RTL and testbench

// - Passive SDRAM-side checker for the controller's power-up init sequence: samples cmd/addr/bank at the SDRAM pins.
// - Verifies command order (pwr-up wait, PRECHARGE-all, >=2 AUTO_REFRESH, LOAD_MODE_REGISTER) and tRP/tRC/tMRD spacing.
// - Captures and decodes the mode register and flags violations. Bench checker and on-chip debug; drives nothing onto the SDRAM.

---
 rtl/sdram_pro_init_monitor_pkg.sv | 49 ++++
 rtl/sdram_pro_gap_timer.sv | 33 +++
 rtl/sdram_pro_init_monitor.sv | 168 ++++++++++++++++
 tb/tb_sdram_pro_init_monitor.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pro_init_monitor_pkg.sv
// Shared types, SDRAM command codes, error codes and mode-word helpers for the power-up init monitor.
package sdram_pro_init_monitor_pkg;

    typedef enum logic [2:0] {
        MON_PWRUP = 3'd0,
        MON_PRE   = 3'd1,
        MON_AR    = 3'd2,
        MON_DONE  = 3'd3,
        MON_ERR   = 3'd4
    } mon_state_t;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_NOP          = 4'b0111;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_ORDER = 3'd1;
    localparam logic [2:0] ERR_PWRUP = 3'd2;
    localparam logic [2:0] ERR_TRP   = 3'd3;
    localparam logic [2:0] ERR_TRC   = 3'd4;
    localparam logic [2:0] ERR_TMRD  = 3'd5;
    localparam logic [2:0] ERR_MODE  = 3'd6;

    // A deselected device (CS_n high) is as idle as an explicit NOP.
    function automatic logic cmd_is_nop(input logic [3:0] cmd);
        return cmd[3] || (cmd == CMD_NOP);
    endfunction

    function automatic logic mode_is_legal(input logic [11:0] a);
        logic cas_ok;
        logic bl_ok;
        cas_ok = (a[6:4] == 3'b010) || (a[6:4] == 3'b011);
        bl_ok  = (a[2] == 1'b0) || (a[2:0] == 3'b111);
        return cas_ok && !a[3] && bl_ok && (a[11:10] == 2'b00);
    endfunction

    function automatic logic [3:0] burst_decode(input logic [2:0] bl);
        case (bl)
            3'b000:  return 4'd1;
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdram_pro_gap_timer.sv
// Saturating cycle-gap counter: a clear marks the timing-reference command, the
// count then equals cycles elapsed since it, compared against tRP/tRC/tMRD.
module sdram_pro_gap_timer #(
    parameter int TRP  = 2,
    parameter int TRC  = 4,
    parameter int TMRD = 3
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear,
    output logic ge_trp,
    output logic ge_trc,
    output logic ge_tmrd
);

    logic [7:0] gap_reg;

    // Loading 1 on the reference cycle makes gap_reg equal to the index difference.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_reg <= 8'd0;
        end else if (clear) begin
            gap_reg <= 8'd1;
        end else if (gap_reg != 8'hFF) begin
            gap_reg <= gap_reg + 8'd1;
        end
    end

    assign ge_trp  = ({24'd0, gap_reg} >= TRP);
    assign ge_trc  = ({24'd0, gap_reg} >= TRC);
    assign ge_tmrd = ({24'd0, gap_reg} >= TMRD);

endmodule

// File: rtl/sdram_pro_init_monitor.sv
// Passive checker of the SDRAM power-up init sequence and mode-register load.
// Define SDRAM_MON_POST_INIT_CHECK_EN to keep checking AR/LMR spacing after init.
module sdram_pro_init_monitor
    import sdram_pro_init_monitor_pkg::*;
#(
    parameter int MIN_PWRUP_CYC = 10000,
    parameter int TRP           = 2,
    parameter int TRC           = 4,
    parameter int TMRD          = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  mon_cmd,
    input  logic [11:0] mon_addr,
    input  logic [1:0]  mon_bank,
    output logic        init_done,
    output logic [11:0] mode_reg,
    output logic [2:0]  cas_lat,
    output logic [3:0]  burst_len,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    localparam int PW = $clog2(MIN_PWRUP_CYC + 1);
    localparam logic [PW-1:0] PWRUP_DONE = PW'(MIN_PWRUP_CYC);

    mon_state_t    state_reg;
    logic [PW-1:0] pwrup_cnt_reg;
    logic [1:0]    ar_cnt_reg;
    logic [2:0]    viol;
    logic          cmd_active, is_pre, is_ar, is_lmr, a10, gap_clear;
    logic          ge_trp, ge_trc, ge_tmrd;

    assign cmd_active = !cmd_is_nop(mon_cmd);
    assign is_pre     = (mon_cmd == CMD_PRECHARGE);
    assign is_ar      = (mon_cmd == CMD_AUTO_REFRESH);
    assign is_lmr     = (mon_cmd == CMD_LOAD_MODE);
    assign a10        = mon_addr[10];
    assign cas_lat    = mode_reg[6:4];

    // tRP is measured from the first PRECHARGE of a run, so repeats do not restart it.
    assign gap_clear = cmd_active && !((state_reg == MON_PRE) && is_pre);

    sdram_pro_gap_timer #(
        .TRP  (TRP),
        .TRC  (TRC),
        .TMRD (TMRD)
    ) u_gap_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (gap_clear),
        .ge_trp    (ge_trp),
        .ge_trc    (ge_trc),
        .ge_tmrd   (ge_tmrd)
    );

`ifdef SDRAM_MON_POST_INIT_CHECK_EN
    logic last_ar_reg, last_lmr_reg;
    logic unused_bank;
    assign unused_bank = ^mon_bank;
`else
    logic unused_inputs;
    assign unused_inputs = ^{mon_bank, ge_tmrd};
`endif

    always_comb begin
        viol = ERR_NONE;
        if (cmd_active) begin
            case (state_reg)
                MON_PWRUP: begin
                    if (!is_pre || !a10)  viol = ERR_ORDER;
                    else if (pwrup_cnt_reg != PWRUP_DONE) viol = ERR_PWRUP;
                end
                MON_PRE: begin
                    if (is_pre) begin
                        if (!a10) viol = ERR_ORDER;
                    end else if (is_ar) begin
                        if (!ge_trp) viol = ERR_TRP;
                    end else begin
                        viol = ERR_ORDER;
                    end
                end
                MON_AR: begin
                    if (is_ar) begin
                        if (!ge_trc) viol = ERR_TRC;
                    end else if (is_lmr) begin
                        if (ar_cnt_reg < 2'd2)          viol = ERR_ORDER;
                        else if (!ge_trc)               viol = ERR_TRC;
                        else if (!mode_is_legal(mon_addr)) viol = ERR_MODE;
                    end else begin
                        viol = ERR_ORDER;
                    end
                end
`ifdef SDRAM_MON_POST_INIT_CHECK_EN
                MON_DONE: begin
                    if (last_ar_reg && !ge_trc)           viol = ERR_TRC;
                    else if (last_lmr_reg && !ge_tmrd)    viol = ERR_TMRD;
                    else if (is_lmr && !mode_is_legal(mon_addr)) viol = ERR_MODE;
                end
`endif
                default: viol = ERR_NONE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= MON_PWRUP;
            pwrup_cnt_reg <= '0;
            ar_cnt_reg    <= 2'd0;
            init_done     <= 1'b0;
            mode_reg      <= 12'h000;
            burst_len     <= 4'd0;
            err_valid     <= 1'b0;
            err_code      <= ERR_NONE;
`ifdef SDRAM_MON_POST_INIT_CHECK_EN
            last_ar_reg   <= 1'b0;
            last_lmr_reg  <= 1'b0;
`endif
        end else begin
            err_valid <= 1'b0;
            if (pwrup_cnt_reg != PWRUP_DONE) begin
                pwrup_cnt_reg <= pwrup_cnt_reg + PW'(1);
            end
`ifdef SDRAM_MON_POST_INIT_CHECK_EN
            if (cmd_active) begin
                last_ar_reg  <= is_ar;
                last_lmr_reg <= is_lmr;
            end
`endif
            if (viol != ERR_NONE) begin
                state_reg <= MON_ERR;
                err_valid <= 1'b1;
                err_code  <= viol;
            end else if (cmd_active) begin
                case (state_reg)
                    MON_PWRUP: state_reg <= MON_PRE;
                    MON_PRE: begin
                        if (is_ar) begin
                            state_reg  <= MON_AR;
                            ar_cnt_reg <= 2'd1;
                        end
                    end
                    MON_AR: begin
                        if (is_ar) begin
                            if (ar_cnt_reg != 2'd3) ar_cnt_reg <= ar_cnt_reg + 2'd1;
                        end else begin
                            mode_reg  <= mon_addr;
                            burst_len <= burst_decode(mon_addr[2:0]);
                            init_done <= 1'b1;
                            state_reg <= MON_DONE;
                        end
                    end
`ifdef SDRAM_MON_POST_INIT_CHECK_EN
                    MON_DONE: begin
                        if (is_lmr) begin
                            mode_reg  <= mon_addr;
                            burst_len <= burst_decode(mon_addr[2:0]);
                        end
                    end
`endif
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_pro_init_monitor.sv
// Self-checking bench: event-level reference model of the init rules, compared every cycle,
// plus directed scenarios with literal expectations and randomized command streams.
module tb_sdram_pro_init_monitor;

    localparam int MIN_PWRUP = 10000;
    localparam int TRP       = 2;
    localparam int TRC       = 4;
    localparam int TMRD      = 3;

    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_AR  = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [3:0] C_NOP = 4'b0111;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  mon_cmd;
    logic [11:0] mon_addr;
    logic [1:0]  mon_bank;
    logic        init_done;
    logic [11:0] mode_reg;
    logic [2:0]  cas_lat;
    logic [3:0]  burst_len;
    logic        err_valid;
    logic [2:0]  err_code;

    always #5 sys_clk = ~sys_clk;

    sdram_pro_init_monitor dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mon_cmd   (mon_cmd),
        .mon_addr  (mon_addr),
        .mon_bank  (mon_bank),
        .init_done (init_done),
        .mode_reg  (mode_reg),
        .cas_lat   (cas_lat),
        .burst_len (burst_len),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (time %0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event/time-stamp based) ----------------
    int          m_t, m_code, m_pre_t, m_n_ar, m_last_t, m_last_kind, m_bl;
    bit          m_done, m_ev;
    logic [11:0] m_mode;

    function automatic bit legal_mode(input logic [11:0] a);
        int cas;
        int bl;
        cas = int'(a[6:4]);
        bl  = int'(a[2:0]);
        return (cas == 2 || cas == 3) && (a[3] == 1'b0) && (bl <= 3 || bl == 7) && (a[11:10] == 2'b00);
    endfunction

    function automatic int burst_of(input int bl);
        return (bl == 7) ? 0 : (1 << bl);
    endfunction

    task automatic model_reset();
        m_t = 0; m_code = 0; m_pre_t = -1; m_n_ar = 0; m_last_t = 0; m_last_kind = 0;
        m_done = 1'b0; m_ev = 1'b0; m_mode = 12'h000; m_bl = 0;
    endtask

    task automatic flag(input int c);
        if (m_code == 0) begin
            m_code = c;
            m_ev = 1'b1;
        end
    endtask

    task automatic capture(input logic [11:0] a);
        m_mode = a;
        m_bl = burst_of(int'(a[2:0]));
    endtask

    // kind: 0 other, 1 AUTO_REFRESH, 2 LOAD_MODE, 3 PRECHARGE
    task automatic model_step(input logic [3:0] c, input logic [11:0] a);
        int gap;
        int kind;
        m_ev = 1'b0;
        if (!(c[3] || c == C_NOP)) begin
            gap  = m_t - m_last_t;
            kind = (c == C_AR) ? 1 : (c == C_LMR) ? 2 : (c == C_PRE) ? 3 : 0;
            if (m_code != 0) begin
                m_code = m_code;
            end else if (m_done) begin
`ifdef SDRAM_MON_POST_INIT_CHECK_EN
                if (m_last_kind == 1 && gap < TRC)       flag(4);
                else if (m_last_kind == 2 && gap < TMRD) flag(5);
                else if (kind == 2) begin
                    if (legal_mode(a)) capture(a);
                    else flag(6);
                end
`endif
            end else begin
                case (kind)
                    3: begin
                        if (!a[10] || m_n_ar > 0) flag(1);
                        else if (m_pre_t < 0) begin
                            if (m_t < MIN_PWRUP) flag(2);
                            else m_pre_t = m_t;
                        end
                    end
                    1: begin
                        if (m_pre_t < 0) flag(1);
                        else if (m_n_ar == 0) begin
                            if (m_t - m_pre_t < TRP) flag(3);
                            else m_n_ar = 1;
                        end else if (gap < TRC) flag(4);
                        else if (m_n_ar < 3) m_n_ar++;
                    end
                    2: begin
                        if (m_n_ar < 2) flag(1);
                        else if (gap < TRC) flag(4);
                        else if (!legal_mode(a)) flag(6);
                        else begin
                            capture(a);
                            m_done = 1'b1;
                        end
                    end
                    default: flag(1);
                endcase
            end
            m_last_t = m_t;
            m_last_kind = kind;
        end
        m_t++;
    endtask

    initial model_reset();

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) model_reset();
        else model_step(mon_cmd, mon_addr);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge sys_clk) begin
        if (cmp_on && n_bad < 100) begin
            check("init_done", int'(init_done), int'(m_done));
            check("mode_reg",  int'(mode_reg),  int'(m_mode));
            check("cas_lat",   int'(cas_lat),   int'(m_mode[6:4]));
            check("burst_len", int'(burst_len), m_bl);
            check("err_valid", int'(err_valid), int'(m_ev));
            check("err_code",  int'(err_code),  m_code);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] c, input logic [11:0] a);
        mon_cmd  = c;
        mon_addr = a;
        mon_bank = 2'($urandom);
        @(negedge sys_clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) send({1'b1, 3'($urandom)}, 12'($urandom));
            else send(C_NOP, 12'($urandom));
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        mon_cmd = C_NOP;
        repeat (3) @(negedge sys_clk);
        if (cmp_on) begin
            check("rst_init_done", int'(init_done), 0);
            check("rst_err_code",  int'(err_code),  0);
            check("rst_mode_reg",  int'(mode_reg),  0);
        end
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic legal_flow();
        nops(MIN_PWRUP);
        send(C_PRE, 12'h400);
        send(C_PRE, 12'h400);
        send(C_AR, 12'h000);
        nops(4);
        send(C_AR, 12'h000);
        nops(4);
        send(C_LMR, 12'h037);
    endtask

    function automatic logic [11:0] pick_mode(input int i);
        case (i)
            0: return 12'h037;
            1: return 12'h027;
            2: return 12'h020;
            3: return 12'h033;
            4: return 12'h047;
            5: return 12'h03B;
            6: return 12'h434;
            7: return 12'h036;
            default: return 12'h007;
        endcase
    endfunction

    function automatic logic [3:0] pick_cmd(input int i);
        case (i)
            0: return C_PRE;
            1: return C_AR;
            2: return C_LMR;
            3: return C_ACT;
            4: return C_RD;
            5: return C_WR;
            default: return C_BST;
        endcase
    endfunction

    task automatic rand_flow();
        int n;
        int sel;
        nops(9998 + $urandom_range(0, 4));
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            send(C_PRE, ($urandom_range(0, 9) != 0) ? 12'h400 : 12'h000);
            if (i < n - 1) nops($urandom_range(0, 1));
        end
        nops($urandom_range(0, 2));
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            send(($urandom_range(0, 9) != 0) ? C_AR : C_ACT, 12'h000);
            nops($urandom_range(2, 5));
        end
        send(C_LMR, pick_mode($urandom_range(0, 8)));
        for (int i = 0; i < 8; i++) begin
            nops($urandom_range(0, 5));
            sel = $urandom_range(0, 4);
            if (sel == 2) send(C_LMR, pick_mode($urandom_range(0, 8)));
            else send(pick_cmd(sel), 12'($urandom));
        end
        nops(2);
        $display("random flow: model init_done=%0d err_code=%0d, dut init_done=%0d err_code=%0d",
                 m_done, m_code, init_done, err_code);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sys_rst_n = 1'b0;
        mon_cmd = C_NOP;
        mon_addr = 12'h000;
        mon_bank = 2'b00;
        $display("bench params: MIN_PWRUP=%0d TRP=%0d TRC=%0d TMRD=%0d", MIN_PWRUP, TRP, TRC, TMRD);
        do_reset();
        cmp_on = 1'b1;

        // Early PRECHARGE at cycle 9998
        nops(9998);
        send(C_PRE, 12'h400);
        check("early_pre_err_valid", int'(err_valid), 1);
        check("early_pre_err_code", int'(err_code), 2);
        check("early_pre_model_code", m_code, 2);
        nops(1);
        check("early_pre_pulse_end", int'(err_valid), 0);
        check("early_pre_init_done", int'(init_done), 0);
        $display("scenario early precharge: err_code=%0d init_done=%0d", err_code, init_done);

        // AR gap exactly TRC passes, then reset while in the AR phase
        do_reset();
        nops(MIN_PWRUP);
        send(C_PRE, 12'h400);
        send(C_PRE, 12'h400);
        send(C_AR, 12'h000);
        nops(3);
        send(C_AR, 12'h000);
        check("ar_gap4_err_code", int'(err_code), 0);
        check("ar_gap4_model_code", m_code, 0);
        $display("scenario ar gap 4 then reset: err_code=%0d", err_code);
        do_reset();

        // Full legal flow
        legal_flow();
        check("legal_init_done", int'(init_done), 1);
        check("legal_cas_lat", int'(cas_lat), 3);
        check("legal_burst_len", int'(burst_len), 0);
        check("legal_err_code", int'(err_code), 0);
        check("legal_mode_reg", int'(mode_reg), 12'h037);
        check("legal_model_done", int'(m_done), 1);
        $display("scenario legal flow: init_done=%0d cas_lat=%0d burst_len=%0d err_code=%0d",
                 init_done, cas_lat, burst_len, err_code);

        // Post-init: LMR, NOP, AR
        nops(4);
        send(C_LMR, 12'h037);
        nops(1);
        send(C_AR, 12'h000);
`ifdef SDRAM_MON_POST_INIT_CHECK_EN
        check("post_tmrd_err_valid", int'(err_valid), 1);
        check("post_tmrd_err_code", int'(err_code), 5);
`else
        check("post_tmrd_err_valid", int'(err_valid), 0);
        check("post_tmrd_err_code", int'(err_code), 0);
`endif
        check("post_tmrd_init_done", int'(init_done), 1);
        $display("scenario post-init lmr/nop/ar: err_code=%0d", err_code);

        // AR gap 3 < TRC
        do_reset();
        nops(MIN_PWRUP);
        send(C_PRE, 12'h400);
        send(C_PRE, 12'h400);
        send(C_AR, 12'h000);
        nops(2);
        send(C_AR, 12'h000);
        check("ar_gap3_err_code", int'(err_code), 4);
        check("ar_gap3_model_code", m_code, 4);
        $display("scenario ar gap 3: err_code=%0d", err_code);

        // Single AR before LMR; PRE->AR gap exactly TRP
        do_reset();
        nops(MIN_PWRUP);
        send(C_PRE, 12'h400);
        nops(1);
        send(C_AR, 12'h000);
        nops(4);
        send(C_LMR, 12'h037);
        check("one_ar_err_code", int'(err_code), 1);
        check("one_ar_init_done", int'(init_done), 0);
        $display("scenario single AR: err_code=%0d", err_code);

        // Illegal CAS latency 4
        do_reset();
        nops(MIN_PWRUP);
        send(C_PRE, 12'h400);
        send(C_PRE, 12'h400);
        send(C_AR, 12'h000);
        nops(4);
        send(C_AR, 12'h000);
        nops(4);
        send(C_LMR, 12'h047);
        check("cas4_err_code", int'(err_code), 6);
        check("cas4_init_done", int'(init_done), 0);
        $display("scenario lmr cas 4: err_code=%0d", err_code);

        // Random short trials before power-up completes
        for (int k = 0; k < 25; k++) begin
            do_reset();
            nops($urandom_range(0, 300));
            send(pick_cmd($urandom_range(0, 6)), 12'($urandom));
            nops(2);
            $display("random early trial %0d: model err_code=%0d dut err_code=%0d", k, m_code, err_code);
        end

        // Random full flow
        do_reset();
        rand_flow();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not reach the end, want completion");
        $fatal(1, "timeout");
    end

endmodule
